sonar_echo_responder: RTL and testbench
=======================================

# sonar_echo_responder

Behavioural-synthesizable HC-SR04 emulator: the responder end of the ultrasonic trigger/echo interface used by the car's distance-measurement block. It accepts the trigger pulse and returns an echo pulse whose width encodes a programmed distance. It replaces the physical sensor in simulation and on the board for hardware-in-the-loop obstacle tests. Its `trig` input connects to the measurement block's trigger output, and its `echo` output drives that block's echo input.

## Interface
- `TRIG_MIN_CYCLES`, default 1000: minimum trigger-high width (10 µs at 100 MHz).
- `BURST_CYCLES`, default 20000: delay from trigger fall to echo rise (200 µs).
- `CYC_PER_CM`, default 5800: echo-high cycles per cm (58 µs/cm).
- `MIN_CM`, default 2: distance clamp floor.
- `MAX_CM`, default 400: largest in-range distance.
- `TIMEOUT_CYCLES`, default 3800000: echo width for out-of-range (38 ms).
- `HOLDOFF_CYCLES`, default 6000000: dead time after echo fall (60 ms).
- `CNT_W`, default 23: width of the shared cycle counter.
- `clk` input 1: system clock (100 MHz).
- `rst` input 1: asynchronous, active-high reset.
- `trig` input 1: trigger from the measurement block. Asynchronous; synchronized internally.
- `distance_cm` input 9: emulated target distance. Sampled once per measurement.
- `echo` output 1: echo pulse. Registered.
- `busy` output 1: high whenever the FSM is not IDLE.
- `trig_err` output 1: one-cycle pulse on a too-short trigger.
- `meas_cnt` output 8: count of completed echoes. Wraps 255→0.

## Operation
- `trig` passes through a 2-FF synchronizer; a third register provides rise/fall detection.
- FSM states: IDLE, TRIG_HI, BURST, ECHO, HOLDOFF.
- **IDLE**
  - On a synchronized rising edge: go to TRIG_HI and load the counter with 1.
  - A `trig` held high out of reset or out of HOLDOFF is not a rising edge and is ignored.
- **TRIG_HI**
  - The counter increments each cycle while the synchronized `trig` is 1.
  - On a falling edge with counter ≥ `TRIG_MIN_CYCLES`: latch the width, then go to BURST.
  - On a falling edge with counter below the minimum: pulse `trig_err` and go to IDLE.
  - The counter saturates at all-ones.
- **Width latch rule**
  - `distance_cm` < `MIN_CM`: width = `MIN_CM`×`CYC_PER_CM`.
  - `distance_cm` > `MAX_CM`: width = `TIMEOUT_CYCLES`.
  - Otherwise: width = `distance_cm`×`CYC_PER_CM`.
  - The product is computed in `CNT_W` bits. `CNT_W` must hold max(`MAX_CM`×`CYC_PER_CM`, `TIMEOUT_CYCLES`, `HOLDOFF_CYCLES`).
- **BURST**: count `BURST_CYCLES` cycles, then set `echo`=1 and go to ECHO.
- **ECHO**
  - `echo` stays high for exactly the latched width in cycles, then drops to 0.
  - `meas_cnt` increments on the same edge that drops `echo`.
  - Next state is HOLDOFF.
- **HOLDOFF**: `trig` activity is ignored and does not raise `trig_err`. After `HOLDOFF_CYCLES` cycles, go to IDLE.
- **Mid-measurement changes**: changes on `distance_cm` after the latch do not affect the current echo.
- **Reset**
  - Reset outputs: `echo`=0, `busy`=0, `trig_err`=0, `meas_cnt`=0.
  - FSM goes to IDLE; counter and synchronizer clear to 0.
  - Reset asserted mid-ECHO drops `echo` asynchronously.

## Timing
- Synchronizer latency: 2 cycles. Edge detect: +1 cycle.
- The measured trigger width equals the pin-high width in cycles (synchronizer delay cancels).
- **Echo rise**: exactly `BURST_CYCLES`+3 cycles after the first rising edge of `clk` that samples `trig`=0 at the pin following a valid trigger.
- **Echo width**: exactly the latched width, ±0 cycles (with the macro off).
- **Measurement period**: IDLE is re-entered exactly `HOLDOFF_CYCLES` cycles after `echo` falls. The earliest accepted new rising edge is in the next cycle.
- **`busy`**: rises 1 cycle after the rise is detected; falls on entry to IDLE.
- **`trig_err`**: asserted for 1 cycle, in the cycle after the fall is detected.

## Configuration
- `SONAR_ECHO_JITTER_EN`, defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per measurement, at the latch.
  - Its low 4 bits, interpreted signed (−8..+7), are added to the in-range width only. The timeout width is never jittered.
  - The result is clamped to ≥1 cycle.
- `SONAR_ECHO_JITTER_EN`, undefined: the LFSR is absent and widths are exact.

## Structure
- Package `sonar_pkg` holds:
  - the state enum (`SONAR_IDLE` … `SONAR_HOLDOFF`);
  - default timing constants shared with the measurement block: `SONAR_CYC_PER_CM`, `SONAR_TRIG_MIN`, `SONAR_TIMEOUT`.
- Sub-module `sonar_lfsr` (enable, seed, 16-bit state) is instantiated only under the macro.
- All other logic, including the synchronizer, stays inline.

## Test plan
Bench overrides: `TRIG_MIN_CYCLES`=10, `BURST_CYCLES`=8, `CYC_PER_CM`=4, `MIN_CM`=2, `MAX_CM`=400, `TIMEOUT_CYCLES`=2000, `HOLDOFF_CYCLES`=50; macro off.
- Valid trigger: `trig` high 12 cycles, `distance_cm`=25 → `echo` rises 11 cycles after `trig` falls, stays high exactly 100 cycles; `meas_cnt` 0→1.
- Short trigger: `trig` high 9 cycles → one-cycle `trig_err`, `echo` stays 0, `busy` returns to 0.
- Clamp and timeout: `distance_cm`=0 → 8-cycle echo; `distance_cm`=401 → 2000-cycle echo; `distance_cm`=400 → 1600-cycle echo.
- Holdoff: new trigger 20 cycles after `echo` falls → ignored, no `trig_err`. Trigger at cycle 55 → accepted.
- Reset mid-ECHO: assert `rst` 30 cycles into a 100-cycle echo → `echo` low immediately, `busy`=0, `meas_cnt`=0. A subsequent valid trigger produces a normal echo.
- `distance_cm` changed from 25 to 300 during BURST → echo width is still 100 cycles.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared types and default timing constants for the HC-SR04 echo responder
// and the distance-measurement block that talks to it.
package sonar_pkg;

  typedef enum logic [2:0] {
    SONAR_IDLE    = 3'd0,
    SONAR_TRIG_HI = 3'd1,
    SONAR_BURST   = 3'd2,
    SONAR_ECHO    = 3'd3,
    SONAR_HOLDOFF = 3'd4
  } sonar_state_e;

  localparam int unsigned SONAR_CYC_PER_CM = 5800;
  localparam int unsigned SONAR_TRIG_MIN   = 1000;
  localparam int unsigned SONAR_TIMEOUT    = 3800000;

endpackage

// File: rtl/sonar_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) for echo-width jitter.
// Only present when SONAR_ECHO_JITTER_EN is defined.
`ifdef SONAR_ECHO_JITTER_EN
module sonar_lfsr (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= seed;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule
`endif

// File: rtl/sonar_echo_responder.sv
// HC-SR04 emulator: answers a trigger pulse with an echo whose width encodes
// distance_cm. Define SONAR_ECHO_JITTER_EN to add LFSR jitter to in-range echoes.
module sonar_echo_responder
  import sonar_pkg::*;
#(
  parameter int unsigned TRIG_MIN_CYCLES = SONAR_TRIG_MIN,
  parameter int unsigned BURST_CYCLES    = 20000,
  parameter int unsigned CYC_PER_CM      = SONAR_CYC_PER_CM,
  parameter int unsigned MIN_CM          = 2,
  parameter int unsigned MAX_CM          = 400,
  parameter int unsigned TIMEOUT_CYCLES  = SONAR_TIMEOUT,
  parameter int unsigned HOLDOFF_CYCLES  = 6000000,
  parameter int unsigned CNT_W           = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       trig_err,
  output logic [7:0] meas_cnt
);

  // [0],[1] synchronizer stages, [2] delayed copy for edge detection
  logic [2:0]       trig_sh_q, trig_sh_d;
  sonar_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] base_c, width_calc_c;
  logic             echo_q, echo_d;
  logic             busy_q, busy_d;
  logic             trig_err_q, trig_err_d;
  logic [7:0]       meas_cnt_q, meas_cnt_d;
  logic             in_range_c;
  logic             rise_c, fall_c, trig_ok_c, latch_c;
  logic             burst_done_c, echo_done_c, hold_done_c;

  assign trig_sh_d    = {trig_sh_q[1:0], trig};
  assign rise_c       = trig_sh_q[1] & ~trig_sh_q[2];
  assign fall_c       = ~trig_sh_q[1] & trig_sh_q[2];
  assign trig_ok_c    = cnt_q >= CNT_W'(TRIG_MIN_CYCLES);
  assign latch_c      = (state_q == SONAR_TRIG_HI) && fall_c && trig_ok_c;
  assign burst_done_c = cnt_q == CNT_W'(BURST_CYCLES);
  assign echo_done_c  = cnt_q == width_q;
  assign hold_done_c  = cnt_q == CNT_W'(HOLDOFF_CYCLES);

`ifdef SONAR_ECHO_JITTER_EN
  logic [15:0]    lfsr_state;
  logic [CNT_W:0] jit_c, jsum_c;

  sonar_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (latch_c),
    .seed  (16'hACE1),
    .state (lfsr_state)
  );

  assign jit_c  = {{(CNT_W-3){lfsr_state[3]}}, lfsr_state[3:0]};
  assign jsum_c = {1'b0, base_c} + jit_c;
`endif

  // Echo width for the sampled distance: clamp low, time out high
  always_comb begin
    in_range_c = 1'b1;
    if (distance_cm < 9'(MIN_CM)) begin
      base_c = CNT_W'(MIN_CM) * CNT_W'(CYC_PER_CM);
    end else if (distance_cm > 9'(MAX_CM)) begin
      base_c     = CNT_W'(TIMEOUT_CYCLES);
      in_range_c = 1'b0;
    end else begin
      base_c = CNT_W'(distance_cm) * CNT_W'(CYC_PER_CM);
    end
    width_calc_c = base_c;
`ifdef SONAR_ECHO_JITTER_EN
    if (in_range_c) begin
      if (jsum_c[CNT_W] || (jsum_c == '0)) width_calc_c = CNT_W'(1);
      else                                 width_calc_c = jsum_c[CNT_W-1:0];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SONAR_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SONAR_IDLE:    if (rise_c)       state_d = SONAR_TRIG_HI;
      SONAR_TRIG_HI: if (fall_c)       state_d = trig_ok_c ? SONAR_BURST : SONAR_IDLE;
      SONAR_BURST:   if (burst_done_c) state_d = SONAR_ECHO;
      SONAR_ECHO:    if (echo_done_c)  state_d = SONAR_HOLDOFF;
      SONAR_HOLDOFF: if (hold_done_c)  state_d = SONAR_IDLE;
      default:                         state_d = SONAR_IDLE;
    endcase
  end

  // Shared counter, width latch and registered outputs
  always_comb begin
    cnt_d      = cnt_q;
    width_d    = width_q;
    echo_d     = echo_q;
    trig_err_d = 1'b0;
    meas_cnt_d = meas_cnt_q;
    busy_d     = state_d != SONAR_IDLE;
    case (state_q)
      SONAR_IDLE: begin
        if (rise_c) cnt_d = CNT_W'(1);
      end
      SONAR_TRIG_HI: begin
        if (fall_c) begin
          if (trig_ok_c) begin
            width_d = width_calc_c;
            cnt_d   = '0;
          end else begin
            trig_err_d = 1'b1;
          end
        end else if (trig_sh_q[1] && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SONAR_BURST: begin
        if (burst_done_c) begin
          echo_d = 1'b1;
          cnt_d  = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SONAR_ECHO: begin
        if (echo_done_c) begin
          echo_d     = 1'b0;
          meas_cnt_d = meas_cnt_q + 8'd1;
          cnt_d      = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SONAR_HOLDOFF: begin
        if (!hold_done_c) cnt_d = cnt_q + CNT_W'(1);
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_sh_q  <= '0;
      cnt_q      <= '0;
      width_q    <= '0;
      echo_q     <= 1'b0;
      busy_q     <= 1'b0;
      trig_err_q <= 1'b0;
      meas_cnt_q <= '0;
    end else begin
      trig_sh_q  <= trig_sh_d;
      cnt_q      <= cnt_d;
      width_q    <= width_d;
      echo_q     <= echo_d;
      busy_q     <= busy_d;
      trig_err_q <= trig_err_d;
      meas_cnt_q <= meas_cnt_d;
    end
  end

  assign echo     = echo_q;
  assign busy     = busy_q;
  assign trig_err = trig_err_q;
  assign meas_cnt = meas_cnt_q;

endmodule

// File: tb/tb_sonar_echo_responder.sv
// Scoreboard bench for sonar_echo_responder: stimulus queues expected echo /
// trig_err events, a negedge monitor measures and checks them.
module tb_sonar_echo_responder;

  localparam int KIND_ECHO = 1;
  localparam int KIND_ERR  = 2;
  localparam int ECHO_DLY  = 11;
  localparam int ERR_DLY   = 2;

  logic       clk;
  logic       rst;
  logic       trig;
  logic [8:0] distance_cm;
  logic       echo;
  logic       busy;
  logic       trig_err;
  logic [7:0] meas_cnt;

  typedef struct {
    int kind;
    int dly;
    int wid;
    int mc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp    = 0;
  int   n_mis    = 0;
  int   n_echo   = 0;
  int   cyc      = 0;
  int   last_fall = 0;
  int   exp_meas = 0;

  sonar_echo_responder #(
    .TRIG_MIN_CYCLES (10),
    .BURST_CYCLES    (8),
    .CYC_PER_CM      (4),
    .MIN_CM          (2),
    .MAX_CM          (400),
    .TIMEOUT_CYCLES  (2000),
    .HOLDOFF_CYCLES  (50),
    .CNT_W           (23)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trig        (trig),
    .distance_cm (distance_cm),
    .echo        (echo),
    .busy        (busy),
    .trig_err    (trig_err),
    .meas_cnt    (meas_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic push_echo(input int wid);
    exp_t e;
    exp_meas = (exp_meas + 1) % 256;
    e.kind = KIND_ECHO; e.dly = ECHO_DLY; e.wid = wid; e.mc = exp_meas;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.kind = KIND_ERR; e.dly = ERR_DLY; e.wid = 1; e.mc = exp_meas;
    sb.push_back(e);
  endtask

  // Pin high for exactly w sampling edges; records the edge that first samples 0
  task automatic do_trig(input int w);
    @(negedge clk);
    trig = 1'b1;
    repeat (w) @(negedge clk);
    trig = 1'b0;
    @(posedge clk);
    #1 last_fall = cyc;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check(nm, busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_echo(input logic lvl, input string nm);
    int n = 0;
    while (echo != lvl && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(nm, echo, lvl);
  endtask

  // Monitor: measures echo / trig_err pulses and compares with the scoreboard
  initial begin
    logic echo_prev = 1'b0;
    logic err_prev  = 1'b0;
    int   rise_cyc  = 0;
    int   err_cyc   = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        echo_prev = 1'b0;
        err_prev  = 1'b0;
      end else begin
        if (echo && !echo_prev) rise_cyc = cyc;
        if (!echo && echo_prev) begin
          if (sb.size() == 0) begin
            n_cmp++; n_mis++;
            $display("FAIL unexpected_echo: got width %0d expected no echo", cyc - rise_cyc);
          end else begin
            e = sb.pop_front();
            n_echo++;
            check("echo_kind", KIND_ECHO, e.kind);
            check("echo_delay", rise_cyc - last_fall, e.dly);
            check("echo_width", cyc - rise_cyc, e.wid);
            check("meas_cnt", int'(meas_cnt), e.mc);
          end
        end
        if (trig_err && !err_prev) begin
          err_cyc = cyc;
          if (sb.size() == 0) begin
            n_cmp++; n_mis++;
            $display("FAIL unexpected_trig_err: got pulse at cycle %0d expected none", cyc);
          end else begin
            e = sb.pop_front();
            check("err_kind", KIND_ERR, e.kind);
            check("err_delay", cyc - last_fall, e.dly);
          end
        end
        if (!trig_err && err_prev) check("err_width", cyc - err_cyc, 1);
        echo_prev = echo;
        err_prev  = trig_err;
      end
    end
  end

  initial begin
    int   dists [3];
    int   widths[3];
    dists  = '{0, 401, 400};
    widths = '{8, 2000, 1600};

    rst = 1'b1;
    trig = 1'b0;
    distance_cm = 9'd0;
    repeat (4) @(negedge clk);
    check("rst_echo", echo, 0);
    check("rst_busy", busy, 0);
    check("rst_trig_err", trig_err, 0);
    check("rst_meas_cnt", int'(meas_cnt), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Valid trigger, 25 cm
    distance_cm = 9'd25;
    push_echo(100);
    do_trig(12);
    check("busy_during_meas", busy, 1);
    wait_idle("idle_after_valid");

    // Too-short trigger
    push_err();
    do_trig(9);
    wait_idle("idle_after_short");
    check("echo_after_short", echo, 0);
    check("meas_after_short", int'(meas_cnt), exp_meas);

    // Clamp floor, timeout, largest in-range
    for (int i = 0; i < 3; i++) begin
      distance_cm = 9'(dists[i]);
      push_echo(widths[i]);
      do_trig(12);
      wait_idle("idle_after_clamp");
    end

    // Holdoff: trigger 20 cycles after echo fall is ignored, at 55 is accepted
    distance_cm = 9'd25;
    push_echo(100);
    do_trig(12);
    wait_echo(1'b1, "holdoff_echo_rise");
    wait_echo(1'b0, "holdoff_echo_fall");
    repeat (19) @(negedge clk);
    do_trig(12);
    check("busy_in_holdoff", busy, 1);
    repeat (21) @(negedge clk);
    push_echo(100);
    do_trig(12);
    wait_idle("idle_after_holdoff");

    // Reset in the middle of an echo
    do_trig(12);
    wait_echo(1'b1, "rst_echo_rise");
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_echo", echo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_meas_cnt", int'(meas_cnt), 0);
    exp_meas = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    push_echo(100);
    do_trig(12);
    wait_idle("idle_after_rst");

    // Distance changes during BURST do not affect the latched width
    distance_cm = 9'd25;
    push_echo(100);
    do_trig(12);
    repeat (4) @(negedge clk);
    distance_cm = 9'd300;
    check("busy_in_burst", busy, 1);
    wait_idle("idle_after_change");

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("echo_count", n_echo, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
